efpga_config_loader: RTL and testbench
======================================

EFPGA_CONFIG_LOADER -- requirements
Module: efpga_config_loader

Interface
REQ-001 SHALL have parameter NumberOfRows, default 3, fabric rows receiving frame data.
REQ-002 SHALL have parameter NumberOfCols, default 5, fabric columns.
REQ-003 SHALL have parameter FrameBitsPerRow, default 32, frame bits per row (equal to the input word width).
REQ-004 SHALL have parameter MaxFramesPerCol, default 36, frames per column.
REQ-005 SHALL have port CLK, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port resetn, input, 1, reset; asynchronous assert, active-low.
REQ-007 SHALL have port s_data, input, 32, bitstream word.
REQ-008 SHALL have port s_valid, input, 1, s_data valid.
REQ-009 SHALL have port s_ready, output, 1, loader accepts a word.
REQ-010 SHALL have port FrameRegister, output, NumberOfRows*32 (96), assembled frame data.
REQ-011 SHALL have port FrameSelect, output, NumberOfCols*MaxFramesPerCol (180), one-hot frame write strobe.
REQ-012 SHALL have port ConfigBusy, output, 1, high from sync word until desync or error.
REQ-013 SHALL have port ConfigDone, output, 1, single-cycle pulse on clean desync.
REQ-014 SHALL have port ConfigError, output, 1, sticky error flag.

Function
REQ-015 SHALL accept a word only on a cycle with s_valid=1 and s_ready=1.
REQ-016 SHALL use states IDLE, HEADER, DATA, STROBE and ERROR; s_ready SHALL be 1 in IDLE, HEADER, DATA and ERROR, and 0 in STROBE.
REQ-017 IDLE: an accepted 32'hFAB0_FAB1 SHALL go to HEADER, set ConfigBusy and clear ConfigError; any other word SHALL be discarded.
REQ-018 Header fields: bit 20 = desync, bits [15:8] = column, bits [7:0] = frame; all other bits are ignored.
REQ-019 HEADER with desync=1 SHALL go to IDLE, clear ConfigBusy and pulse ConfigDone for one cycle.
REQ-020 HEADER with desync=0 and column>=NumberOfCols or frame>=MaxFramesPerCol SHALL go to ERROR, set ConfigError and clear ConfigBusy.
REQ-021 A valid header SHALL latch column and frame and go to DATA with the row counter at 0.
REQ-022 DATA SHALL accept NumberOfRows words: the first word goes to FrameRegister[95:64] and the last to [31:0]; after the last word the state SHALL be STROBE.
REQ-023 STROBE SHALL last exactly one cycle and assert FrameSelect[column*MaxFramesPerCol+frame] only, then go to HEADER.
REQ-024 FrameSelect SHALL be all-zero outside STROBE; at most one bit SHALL ever be set.
REQ-025 FrameRegister SHALL hold its value from STROBE until the next accepted DATA word.
REQ-026 ERROR SHALL discard words until the sync word is accepted, then behave as REQ-017.
REQ-027 A sync word received in HEADER or DATA SHALL be treated as ordinary data, not as a resync.

Reset
REQ-028 While resetn=0: state IDLE, FrameRegister=0, FrameSelect=0, ConfigBusy=0, ConfigDone=0, ConfigError=0, row counter=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no FrameSelect pulse; words presented while resetn=0 SHALL be ignored.

Configuration
REQ-030 With CONFIG_LOADER_CHECKSUM_EN defined: a 32-bit modulo-2^32 sum of all DATA words since sync SHALL be kept, and a desync header SHALL be followed by one checksum word.
REQ-031 In that mode a checksum match SHALL behave as REQ-019; a mismatch SHALL go to ERROR with ConfigError=1 and no ConfigDone.
REQ-032 Without CONFIG_LOADER_CHECKSUM_EN: no checksum register or state SHALL exist, and desync SHALL complete immediately per REQ-019.

Structure
REQ-033 Package efpga_cfg_pkg SHALL hold the sync word constant, the header bit positions (desync=20), the state enum and the geometry defaults.
REQ-034 Sub-module efpga_frame_select_decoder SHALL map (column, frame, strobe) to the one-hot FrameSelect vector.

Verification
REQ-035 Reset, then sync, header col=2 frame=5, data 0x11111111, 0x22222222, 0x33333333 -> FrameRegister=0x111111112222222233333333 and FrameSelect bit 77 high for exactly one cycle.
REQ-036 Sync then header col=5 -> ConfigError=1, ConfigBusy=0, no strobe; a later sync clears ConfigError.
REQ-037 Two back-to-back frames with s_valid held high -> s_ready=0 in each strobe cycle, two separate strobes, no word lost.
REQ-038 Desync header (0x00100000) -> one ConfigDone pulse, ConfigBusy=0, return to IDLE; with CHECKSUM_EN, a wrong checksum word -> ConfigError=1 and no ConfigDone.
REQ-039 resetn pulled low after the second DATA word -> all outputs zero, no FrameSelect pulse; the next full sequence loads correctly.
REQ-040 Non-sync words 0xDEADBEEF presented in IDLE -> discarded, ConfigBusy stays 0.

Source files
------------

// File: rtl/efpga_config_loader_pkg.sv
// efpga_cfg_pkg: shared constants and types for the eFPGA configuration loader.
//   - bitstream sync word
//   - header field positions
//   - loader state encoding
//   - default fabric geometry
// CONFIG_LOADER_CHECKSUM_EN adds the checksum state to the state enum.
package efpga_cfg_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] SYNC_WORD = 32'hFAB0_FAB1;

  // Header word layout: [20] desync, [15:8] column, [7:0] frame.
  localparam int unsigned HDR_DESYNC_BIT = 20;
  localparam int unsigned HDR_COL_LSB    = 8;
  localparam int unsigned HDR_FRAME_LSB  = 0;
  localparam int unsigned HDR_FIELD_W    = 8;

  localparam int unsigned DEF_ROWS           = 3;
  localparam int unsigned DEF_COLS           = 5;
  localparam int unsigned DEF_FRAME_BITS     = 32;
  localparam int unsigned DEF_FRAMES_PER_COL = 36;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA,
    ST_STROBE,
    ST_ERROR
`ifdef CONFIG_LOADER_CHECKSUM_EN
    , ST_CHECKSUM
`endif
  } state_t;

endpackage

// File: rtl/efpga_config_loader_if.sv
// efpga_config_loader_if: valid/ready bitstream word stream into the loader.
//   s_data  : bitstream word (master -> slave)
//   s_valid : s_data valid (master -> slave)
//   s_ready : loader accepts a word (slave -> master)
interface efpga_config_loader_if;
  import efpga_cfg_pkg::*;

  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/efpga_config_loader_decoder.sv
// efpga_frame_select_decoder: turns a latched (column, frame) pair plus a
// strobe into the one-hot FrameSelect vector, bit column*MaxFramesPerCol+frame.
//   column, frame : latched header fields
//   strobe        : high for the single write cycle
//   select        : one-hot frame write strobe, all-zero when strobe is low
module efpga_frame_select_decoder
  import efpga_cfg_pkg::*;
#(
  parameter int unsigned NumberOfCols    = DEF_COLS,
  parameter int unsigned MaxFramesPerCol = DEF_FRAMES_PER_COL
) (
  input  logic [HDR_FIELD_W-1:0]                  column,
  input  logic [HDR_FIELD_W-1:0]                  frame,
  input  logic                                    strobe,
  output logic [NumberOfCols*MaxFramesPerCol-1:0] select
);

  always_comb begin
    select = '0;
    for (int unsigned c = 0; c < NumberOfCols; c++) begin
      for (int unsigned f = 0; f < MaxFramesPerCol; f++) begin
        select[c*MaxFramesPerCol+f] = strobe
                                      && (column == HDR_FIELD_W'(c))
                                      && (frame == HDR_FIELD_W'(f));
      end
    end
  end

endmodule

// File: rtl/efpga_config_loader.sv
// efpga_config_loader: parses a word-serial configuration bitstream
// (sync word, then header / data frames, then a desync header) and writes
// assembled frames into the fabric through a one-hot frame strobe.
//   CLK, resetn   : clock, asynchronous active-low reset
//   bus (slave)   : s_data / s_valid / s_ready word stream
//   FrameRegister : assembled frame, first row word in the top slice
//   FrameSelect   : one-hot frame write strobe, one cycle per frame
//   ConfigBusy    : high from sync word until desync or error
//   ConfigDone    : one-cycle pulse on clean desync
//   ConfigError   : sticky error, cleared by the next sync word
// Optional macro CONFIG_LOADER_CHECKSUM_EN: a desync header is followed by a
// word that must equal the 32-bit sum of all data words since sync.
module efpga_config_loader
  import efpga_cfg_pkg::*;
#(
  parameter int unsigned NumberOfRows    = DEF_ROWS,
  parameter int unsigned NumberOfCols    = DEF_COLS,
  parameter int unsigned FrameBitsPerRow = DEF_FRAME_BITS,
  parameter int unsigned MaxFramesPerCol = DEF_FRAMES_PER_COL
) (
  input  logic                                    CLK,
  input  logic                                    resetn,
  efpga_config_loader_if.slave                    bus,
  output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameRegister,
  output logic [NumberOfCols*MaxFramesPerCol-1:0] FrameSelect,
  output logic                                    ConfigBusy,
  output logic                                    ConfigDone,
  output logic                                    ConfigError
);

  localparam int unsigned RowW = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;

  state_t state, state_next;

  logic                   ready;
  logic                   accept;
  logic                   busy_next, done_next, error_next;
  logic                   load_hdr, load_word;
  logic [RowW-1:0]        row;
  logic                   row_last;
  logic [HDR_FIELD_W-1:0] col_q, frame_q;
  logic [HDR_FIELD_W-1:0] hdr_col, hdr_frame;
  logic                   hdr_desync, hdr_bad;
`ifdef CONFIG_LOADER_CHECKSUM_EN
  logic                   clear_sum;
  logic [WORD_W-1:0]      checksum;
`endif

  assign ready       = (state != ST_STROBE);
  assign bus.s_ready = ready;
  assign accept      = bus.s_valid && ready;

  assign hdr_col    = bus.s_data[HDR_COL_LSB +: HDR_FIELD_W];
  assign hdr_frame  = bus.s_data[HDR_FRAME_LSB +: HDR_FIELD_W];
  assign hdr_desync = bus.s_data[HDR_DESYNC_BIT];
  assign hdr_bad    = (32'(hdr_col) >= NumberOfCols) || (32'(hdr_frame) >= MaxFramesPerCol);
  assign row_last   = (row == RowW'(NumberOfRows - 1));

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      ConfigBusy  <= 1'b0;
      ConfigDone  <= 1'b0;
      ConfigError <= 1'b0;
    end else begin
      state       <= state_next;
      ConfigBusy  <= busy_next;
      ConfigDone  <= done_next;
      ConfigError <= error_next;
    end
  end

  always_comb begin
    state_next = state;
    busy_next  = ConfigBusy;
    done_next  = 1'b0;
    error_next = ConfigError;
    load_hdr   = 1'b0;
    load_word  = 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
    clear_sum  = 1'b0;
`endif
    unique case (state)
      // The sync word is only recognised here; inside a frame it is data.
      ST_IDLE, ST_ERROR: begin
        if (accept && (bus.s_data == SYNC_WORD)) begin
          state_next = ST_HEADER;
          busy_next  = 1'b1;
          error_next = 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
          clear_sum  = 1'b1;
`endif
        end
      end
      ST_HEADER: begin
        if (accept) begin
          if (hdr_desync) begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
            state_next = ST_CHECKSUM;
`else
            state_next = ST_IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
`endif
          end else if (hdr_bad) begin
            state_next = ST_ERROR;
            busy_next  = 1'b0;
            error_next = 1'b1;
          end else begin
            state_next = ST_DATA;
            load_hdr   = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          load_word = 1'b1;
          if (row_last) begin
            state_next = ST_STROBE;
          end
        end
      end
      ST_STROBE: begin
        state_next = ST_HEADER;
      end
`ifdef CONFIG_LOADER_CHECKSUM_EN
      ST_CHECKSUM: begin
        if (accept) begin
          busy_next = 1'b0;
          if (bus.s_data == checksum) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = ST_ERROR;
            error_next = 1'b1;
          end
        end
      end
`endif
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Row slot r lands at the top-down position so the first word ends up in
  // the most significant slice.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      FrameRegister <= '0;
      row           <= '0;
      col_q         <= '0;
      frame_q       <= '0;
    end else begin
      if (load_hdr) begin
        col_q   <= hdr_col;
        frame_q <= hdr_frame;
        row     <= '0;
      end
      if (load_word) begin
        for (int unsigned r = 0; r < NumberOfRows; r++) begin
          if (row == RowW'(r)) begin
            FrameRegister[(NumberOfRows-1-r)*FrameBitsPerRow +: FrameBitsPerRow] <= bus.s_data;
          end
        end
        row <= row_last ? '0 : row + RowW'(1);
      end
    end
  end

`ifdef CONFIG_LOADER_CHECKSUM_EN
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      checksum <= '0;
    end else if (clear_sum) begin
      checksum <= '0;
    end else if (load_word) begin
      checksum <= checksum + bus.s_data;
    end
  end
`endif

  efpga_frame_select_decoder #(
    .NumberOfCols    (NumberOfCols),
    .MaxFramesPerCol (MaxFramesPerCol)
  ) u_decoder (
    .column (col_q),
    .frame  (frame_q),
    .strobe (state == ST_STROBE),
    .select (FrameSelect)
  );

endmodule

// File: tb/tb_efpga_config_loader.sv
// Testbench for efpga_config_loader: table of per-cycle stimulus and expected
// outputs, plus directed sequences for error recovery and mid-frame reset.
module tb_efpga_config_loader;

  localparam int unsigned ROWS = 3;
  localparam int unsigned COLS = 5;
  localparam int unsigned FPC  = 36;

  logic CLK = 1'b0;
  logic resetn = 1'b0;
  logic [ROWS*32-1:0]  FrameRegister;
  logic [COLS*FPC-1:0] FrameSelect;
  logic ConfigBusy, ConfigDone, ConfigError;

  int n_checks = 0;
  int n_errors = 0;
  int strobe_count = 0;

  efpga_config_loader_if bus ();

  efpga_config_loader #(
    .NumberOfRows    (ROWS),
    .NumberOfCols    (COLS),
    .FrameBitsPerRow (32),
    .MaxFramesPerCol (FPC)
  ) dut (
    .CLK           (CLK),
    .resetn        (resetn),
    .bus           (bus.slave),
    .FrameRegister (FrameRegister),
    .FrameSelect   (FrameSelect),
    .ConfigBusy    (ConfigBusy),
    .ConfigDone    (ConfigDone),
    .ConfigError   (ConfigError)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        ready;
    logic        busy;
    logic        done;
    logic        err;
    int          sel;
    logic [95:0] fr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [31:0] d, logic rdy, logic bsy,
                              logic dn, logic er, int sel, logic [95:0] fr);
    vec_t t;
    t.valid = v; t.data = d; t.ready = rdy; t.busy = bsy;
    t.done = dn; t.err = er; t.sel = sel; t.fr = fr;
    return t;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [COLS*FPC-1:0] onehot(int idx);
    logic [COLS*FPC-1:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  task automatic cycle(input logic v, input logic [31:0] d);
    @(negedge CLK);
    bus.s_valid = v;
    bus.s_data  = d;
    #1;
  endtask

  task automatic check_outs(input string tag, input logic rdy, input logic bsy,
                            input logic dn, input logic er, input int sel);
    check({tag, " ready"}, 256'(bus.s_ready), 256'(rdy));
    check({tag, " busy"},  256'(ConfigBusy),  256'(bsy));
    check({tag, " done"},  256'(ConfigDone),  256'(dn));
    check({tag, " error"}, 256'(ConfigError), 256'(er));
    check({tag, " sel"},   256'(FrameSelect), 256'(onehot(sel)));
  endtask

  // Strobe monitor: every non-zero FrameSelect must be exactly one-hot.
  always @(negedge CLK) begin
    if (FrameSelect != '0) begin
      strobe_count++;
      n_checks++;
      if ($countones(FrameSelect) != 1) begin
        n_errors++;
        $display("FAIL onehot: got %0d bits set required 1", $countones(FrameSelect));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;

    // Reset state, including words offered while reset is held.
    cycle(1'b1, 32'hFAB0_FAB1);
    cycle(1'b1, 32'h0000_0205);
    check_outs("reset", 1'b1, 1'b0, 1'b0, 1'b0, -1);
    check("reset fr", 256'(FrameRegister), 256'(96'h0));
    @(negedge CLK);
    resetn = 1'b1;
    bus.s_valid = 1'b0;

    vecs.push_back(mk(1, 32'hDEADBEEF, 1, 0, 0, 0, -1, 96'h0));
    vecs.push_back(mk(1, 32'hDEADBEEF, 1, 0, 0, 0, -1, 96'h0));
    vecs.push_back(mk(1, 32'hFAB0FAB1, 1, 0, 0, 0, -1, 96'h0));
    vecs.push_back(mk(1, 32'h00000205, 1, 1, 0, 0, -1, 96'h0));
    vecs.push_back(mk(1, 32'h11111111, 1, 1, 0, 0, -1, 96'h0));
    vecs.push_back(mk(1, 32'h22222222, 1, 1, 0, 0, -1, 96'h11111111_00000000_00000000));
    vecs.push_back(mk(1, 32'h33333333, 1, 1, 0, 0, -1, 96'h11111111_22222222_00000000));
    vecs.push_back(mk(1, 32'h00000000, 0, 1, 0, 0, 77, 96'h11111111_22222222_33333333));
    vecs.push_back(mk(1, 32'h00000000, 1, 1, 0, 0, -1, 96'h11111111_22222222_33333333));
    vecs.push_back(mk(1, 32'hAAAAAAAA, 1, 1, 0, 0, -1, 96'h11111111_22222222_33333333));
    vecs.push_back(mk(1, 32'hBBBBBBBB, 1, 1, 0, 0, -1, 96'hAAAAAAAA_22222222_33333333));
    vecs.push_back(mk(1, 32'hCCCCCCCC, 1, 1, 0, 0, -1, 96'hAAAAAAAA_BBBBBBBB_33333333));
    vecs.push_back(mk(1, 32'h00000123, 0, 1, 0, 0, 0,  96'hAAAAAAAA_BBBBBBBB_CCCCCCCC));
    vecs.push_back(mk(1, 32'h00000123, 1, 1, 0, 0, -1, 96'hAAAAAAAA_BBBBBBBB_CCCCCCCC));
    vecs.push_back(mk(1, 32'h00000001, 1, 1, 0, 0, -1, 96'hAAAAAAAA_BBBBBBBB_CCCCCCCC));
    vecs.push_back(mk(1, 32'hFAB0FAB1, 1, 1, 0, 0, -1, 96'h00000001_BBBBBBBB_CCCCCCCC));
    vecs.push_back(mk(1, 32'h00000003, 1, 1, 0, 0, -1, 96'h00000001_FAB0FAB1_CCCCCCCC));
    vecs.push_back(mk(1, 32'h00100000, 0, 1, 0, 0, 71, 96'h00000001_FAB0FAB1_00000003));
    vecs.push_back(mk(1, 32'h00100000, 1, 1, 0, 0, -1, 96'h00000001_FAB0FAB1_00000003));
`ifdef CONFIG_LOADER_CHECKSUM_EN
    vecs.push_back(mk(1, 32'h944A944C, 1, 1, 0, 0, -1, 96'h00000001_FAB0FAB1_00000003));
`endif
    vecs.push_back(mk(0, 32'h00000000, 1, 0, 1, 0, -1, 96'h00000001_FAB0FAB1_00000003));
    vecs.push_back(mk(0, 32'h00000000, 1, 0, 0, 0, -1, 96'h00000001_FAB0FAB1_00000003));
    vecs.push_back(mk(1, 32'hDEADBEEF, 1, 0, 0, 0, -1, 96'h00000001_FAB0FAB1_00000003));
    vecs.push_back(mk(1, 32'hDEADBEEF, 1, 0, 0, 0, -1, 96'h00000001_FAB0FAB1_00000003));

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("v%0d", i);
      cycle(vecs[i].valid, vecs[i].data);
      check_outs(tag, vecs[i].ready, vecs[i].busy, vecs[i].done, vecs[i].err, vecs[i].sel);
      check({tag, " fr"}, 256'(FrameRegister), 256'(vecs[i].fr));
    end

    // Bad column, words discarded in ERROR, resync clears the error;
    // then a bad frame index (36) on the frame boundary.
    cycle(1'b1, 32'hFAB0_FAB1);
    cycle(1'b1, 32'h0000_0500);
    check_outs("col5 hdr", 1'b1, 1'b1, 1'b0, 1'b0, -1);
    cycle(1'b1, 32'h1111_1111);
    check_outs("col5 err", 1'b1, 1'b0, 1'b0, 1'b1, -1);
    cycle(1'b1, 32'hFAB0_FAB1);
    check_outs("err discard", 1'b1, 1'b0, 1'b0, 1'b1, -1);
    cycle(1'b1, 32'h0000_0024);
    check_outs("resync", 1'b1, 1'b1, 1'b0, 1'b0, -1);
    cycle(1'b0, 32'h0);
    check_outs("frame36 err", 1'b1, 1'b0, 1'b0, 1'b1, -1);
    cycle(1'b1, 32'hFAB0_FAB1);
    cycle(1'b1, 32'h0000_0423);
    check_outs("resync2", 1'b1, 1'b1, 1'b0, 1'b0, -1);

    // Reset after the second data word aborts the frame.
    cycle(1'b1, 32'hCAFE_F00D);
    cycle(1'b1, 32'h1234_5678);
    @(negedge CLK);
    #2;
    resetn = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h4444_4444;
    #1;
    check_outs("midreset", 1'b1, 1'b0, 1'b0, 1'b0, -1);
    check("midreset fr", 256'(FrameRegister), 256'(96'h0));
    cycle(1'b1, 32'h0BAD_C0DE);
    cycle(1'b1, 32'h5555_5555);
    check_outs("held reset", 1'b1, 1'b0, 1'b0, 1'b0, -1);
    check("held reset fr", 256'(FrameRegister), 256'(96'h0));
    @(negedge CLK);
    resetn = 1'b1;
    bus.s_valid = 1'b0;

    // Full frame after reset, top column / top frame boundary.
    cycle(1'b1, 32'hFAB0_FAB1);
    check_outs("post idle", 1'b1, 1'b0, 1'b0, 1'b0, -1);
    cycle(1'b1, 32'h0000_0423);
    cycle(1'b1, 32'hCAFE_F00D);
    cycle(1'b1, 32'h1234_5678);
    cycle(1'b1, 32'h0BAD_C0DE);
    cycle(1'b0, 32'h0);
    check_outs("post strobe", 1'b0, 1'b1, 1'b0, 1'b0, 179);
    check("post fr", 256'(FrameRegister), 256'(96'hCAFEF00D_12345678_0BADC0DE));
    cycle(1'b0, 32'h0);
    check_outs("post hdr", 1'b1, 1'b1, 1'b0, 1'b0, -1);
    check("post fr hold", 256'(FrameRegister), 256'(96'hCAFEF00D_12345678_0BADC0DE));

`ifdef CONFIG_LOADER_CHECKSUM_EN
    cycle(1'b1, 32'h0010_0000);
    cycle(1'b1, 32'hBADB_AD00);
    check_outs("cs word", 1'b1, 1'b1, 1'b0, 1'b0, -1);
    cycle(1'b0, 32'h0);
    check_outs("cs bad", 1'b1, 1'b0, 1'b0, 1'b1, -1);
    cycle(1'b0, 32'h0);
    check_outs("cs bad2", 1'b1, 1'b0, 1'b0, 1'b1, -1);
`else
    cycle(1'b1, 32'h0010_0000);
    cycle(1'b0, 32'h0);
    check_outs("desync", 1'b1, 1'b0, 1'b1, 1'b0, -1);
    cycle(1'b0, 32'h0);
    check_outs("desync2", 1'b1, 1'b0, 1'b0, 1'b0, -1);
`endif

    check("strobe count", 256'(strobe_count), 256'(4));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
